glitc_clock_phase_scan: RTL and testbench
=========================================

Name: glitc_clock_phase_scan

Overview:
- Automatic phase-alignment controller for the GLITC clock-path IDELAY taps, generalised to NUM_CHANNELS channels.
- For each enabled channel it sweeps every IDELAY tap, majority-votes the registered clock sample at each tap, and finds the first transition.
- It then loads edge + CENTER_OFFSET (mod tap range) into that channel's IDELAY.
- It sits between the per-channel clock-path wrappers (sample source, delay/load sink) and the control register block (start/mask/status).

Parameters:
- NUM_CHANNELS, 4, number of clock-path channels scanned.
- CHAN_BITS, 2, width of the channel index; must satisfy 2^CHAN_BITS >= NUM_CHANNELS.
- TAP_BITS, 5, IDELAY tap value width; the tap range is 0..2^TAP_BITS-1.
- SETTLE_CYCLES, 8, cycles waited after each load before sampling; must be >= 1.
- SAMPLE_BITS, 6, log2 of the number of samples accumulated per tap (64).
- CENTER_OFFSET, 16, taps added to the detected edge to form the final delay.

Ports:
- clk_i, in, 1, single clock for all logic; samples already synchronous to it.
- rst_n_i, in, 1, asynchronous active-low reset.
- start_i, in, 1, single-cycle scan request.
- chan_mask_i, in, NUM_CHANNELS, channel enables; captured on start acceptance.
- sample_i, in, NUM_CHANNELS, registered clock sample per channel.
- delay_o, out, NUM_CHANNELS*TAP_BITS, per-channel IDELAY value; channel c is in bits [c*TAP_BITS +: TAP_BITS].
- load_o, out, NUM_CHANNELS, per-channel one-cycle IDELAY load strobe.
- busy_o, out, 1, high while a scan is in progress.
- done_o, out, 1, one-cycle pulse when the scan completes.
- edge_found_o, out, NUM_CHANNELS, set if an edge was found on the last scan of that channel.
- scan_chan_o, out, CHAN_BITS, index of the channel currently being scanned.

Behaviour:
- Clock and reset: one clock, clk_i; reset is asynchronous and active-low on rst_n_i.
- Reset values:
  - delay_o = 0, load_o = 0, busy_o = 0, done_o = 0, edge_found_o = 0, scan_chan_o = 0.
  - FSM = IDLE, all counters = 0.
  - Reset asserted mid-scan aborts immediately to these values; no completion pulse is issued.
- IDLE:
  - start_i = 1 captures chan_mask_i and moves to SELECT; busy_o rises on the next cycle.
  - start_i while busy_o is high is ignored.
- SELECT:
  - Advances to the lowest enabled, not-yet-scanned channel; scan_chan_o = that channel.
  - Clears that channel's edge_found bit and sets tap = 0, edge_seen = 0.
  - If no channel remains, goes to FINISH.
- LOAD (1 cycle): delay_o[ch] = tap, load_o[ch] = 1 (one-hot); all other load_o bits are 0.
- SETTLE: waits SETTLE_CYCLES cycles; sample_i is ignored.
- ACCUM:
  - Runs exactly 2^SAMPLE_BITS cycles, adding sample_i[ch] to a SAMPLE_BITS+1 bit counter.
  - The counter cannot overflow.
- EVAL (1 cycle):
  - class = (count >= 2^(SAMPLE_BITS-1)).
  - If tap > 0, class != prev_class and edge_seen = 0: record edge_tap = tap and set edge_seen.
  - Only the first edge is recorded; later transitions are ignored.
  - Then prev_class = class and the counter is cleared.
  - If tap = 2^TAP_BITS-1, go to APPLY; otherwise increment tap and go to LOAD.
- APPLY (1 cycle):
  - If edge_seen: delay_o[ch] = (edge_tap + CENTER_OFFSET) mod 2^TAP_BITS (natural TAP_BITS wrap) and edge_found_o[ch] = 1.
  - Otherwise: delay_o[ch] = 0 and edge_found_o[ch] = 0.
  - load_o[ch] = 1, then back to SELECT.
- FINISH (1 cycle): done_o = 1, busy_o falls on the next cycle, go to IDLE.
- Masking:
  - Masked channels receive no load_o pulses.
  - Their delay_o and edge_found_o bits hold their previous values.
- Empty mask: start_i leads to SELECT, then FINISH; done_o pulses 2 cycles after start_i.
- Timing per enabled channel:
  - SELECT takes 1 cycle.
  - Each tap takes 1 + SETTLE_CYCLES + 2^SAMPLE_BITS + 1 cycles (74 with defaults).
  - There are 2^TAP_BITS taps, then 1 APPLY cycle.
  - Total with defaults = 1 + 32*74 + 1 = 2370 cycles.
  - The channel is scanned with exactly 2^TAP_BITS + 1 load pulses.
- Samples are never tied into any other channel's vote.

Test Plan:
- Reset: hold rst_n_i low, then release with no start -> all outputs 0. Assert rst_n_i low at tap 12 of a scan -> load_o, busy_o and delay_o are 0 within the same cycle; done_o never pulses.
- Single edge: mask 4'b0001; the model drives sample_i[0] = (delay_o[0] >= 10) -> edge_tap 10, final delay_o[0] = 26, edge_found_o[0] = 1. The bench checks 33 load_o[0] pulses and done_o exactly 2372 cycles after start_i.
- Wrap-around: mask 4'b0010, falling edge at tap 20 -> delay_o[1] = 4, edge_found_o[1] = 1. A second transition at tap 27 is ignored.
- No edge: sample_i[2] held at 1 with mask 4'b0100 -> delay_o[2] = 0, edge_found_o[2] = 0.
- Majority threshold: at tap 5, drive 31/64 ones, then 32/64 ones at tap 6, with class 0 for taps below 5 -> edge_tap = 6, delay_o = 22.
- Masking, empty mask and re-start:
  - Preset ch1 to delay 7 and edge_found 1 from a prior scan.
  - Scan with mask 4'b0101 -> scan_chan_o visits only 0 then 2; ch1 and ch3 delay_o and edge_found_o are unchanged.
  - start_i while busy is ignored.
  - Mask 0 -> done_o pulses 2 cycles after start_i.

Source files
------------

// File: rtl/glitc_clock_phase_scan.sv
// GLITC clock-path IDELAY phase scan: sweeps every tap per channel,
// majority-votes the clock sample, and centres the delay on the first edge.
module glitc_clock_phase_scan #(
  parameter int NUM_CHANNELS  = 4,
  parameter int CHAN_BITS     = 2,
  parameter int TAP_BITS      = 5,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_BITS   = 6,
  parameter int CENTER_OFFSET = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic [NUM_CHANNELS-1:0]      chan_mask_i,
  input  logic [NUM_CHANNELS-1:0]      sample_i,
  output logic [NUM_CHANNELS*TAP_BITS-1:0] delay_o,
  output logic [NUM_CHANNELS-1:0]      load_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [NUM_CHANNELS-1:0]      edge_found_o,
  output logic [CHAN_BITS-1:0]         scan_chan_o
);

  localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int HALF_I = 1 << (SAMPLE_BITS - 1);

  localparam logic [SET_W-1:0] SET_LAST =
    SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SAMPLE_BITS:0] HALF =
    (SAMPLE_BITS + 1)'(HALF_I);
  localparam logic [TAP_BITS-1:0] TAP_MAX = '1;
  localparam logic [TAP_BITS-1:0] OFFSET =
    TAP_BITS'(CENTER_OFFSET);

  typedef enum logic [2:0] {
    IDLE, SELECT, LOAD, SETTLE,
    ACCUM, EVAL, APPLY, FINISH
  } state_t;

  state_t                            state;
  logic [NUM_CHANNELS-1:0]           pending;
  logic [NUM_CHANNELS-1:0][TAP_BITS-1:0] delay_q;
  logic [NUM_CHANNELS-1:0]           load_q;
  logic [NUM_CHANNELS-1:0]           found_q;
  logic [CHAN_BITS-1:0]              chan_q;
  logic                              busy_q;
  logic                              done_q;
  logic [TAP_BITS-1:0]               tap;
  logic [TAP_BITS-1:0]               edge_tap;
  logic                              edge_seen;
  logic                              prev_cls;
  logic [SET_W-1:0]                  settle_cnt;
  logic [SAMPLE_BITS-1:0]            smp_cnt;
  logic [SAMPLE_BITS:0]              acc;

  logic                              cls;
  logic                              hit;
  logic [TAP_BITS-1:0]               edge_val;
  logic [CHAN_BITS-1:0]              next_chan;
  logic [NUM_CHANNELS-1:0]           cur_hot;
  logic [NUM_CHANNELS-1:0]           next_hot;

  function automatic logic [CHAN_BITS-1:0] first_chan(
    input logic [NUM_CHANNELS-1:0] m
  );
    first_chan = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--)
      if (m[i]) first_chan = CHAN_BITS'(i);
  endfunction

  assign cls       = (acc >= HALF);
  assign hit       = (tap != '0) && (cls != prev_cls) && !edge_seen;
  assign edge_val  = hit ? tap : edge_tap;
  assign next_chan = first_chan(pending);
  assign cur_hot   = NUM_CHANNELS'(1) << chan_q;
  assign next_hot  = NUM_CHANNELS'(1) << next_chan;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      pending    <= '0;
      delay_q    <= '0;
      load_q     <= '0;
      found_q    <= '0;
      chan_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tap        <= '0;
      edge_tap   <= '0;
      edge_seen  <= 1'b0;
      prev_cls   <= 1'b0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      acc        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          load_q <= '0;
          done_q <= 1'b0;
          if (start_i) begin
            pending <= chan_mask_i;
            busy_q  <= 1'b1;
            state   <= SELECT;
          end
        end
        SELECT: begin
          if (pending != '0) begin
            chan_q             <= next_chan;
            pending[next_chan] <= 1'b0;
            found_q[next_chan] <= 1'b0;
            delay_q[next_chan] <= '0;
            load_q             <= next_hot;
            tap                <= '0;
            edge_seen          <= 1'b0;
            acc                <= '0;
            state              <= LOAD;
          end else begin
            done_q <= 1'b1;
            state  <= FINISH;
          end
        end
        LOAD: begin
          load_q     <= '0;
          settle_cnt <= '0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == SET_LAST) begin
            smp_cnt <= '0;
            state   <= ACCUM;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ACCUM: begin
          acc     <= acc + {{SAMPLE_BITS{1'b0}}, sample_i[chan_q]};
          smp_cnt <= smp_cnt + 1'b1;
          if (smp_cnt == '1) state <= EVAL;
        end
        EVAL: begin
          if (hit) begin
            edge_seen <= 1'b1;
            edge_tap  <= tap;
          end
          prev_cls <= cls;
          acc      <= '0;
          load_q   <= cur_hot;
          if (tap == TAP_MAX) begin
            // edge may be recorded on this very tap, so use hit directly
            if (edge_seen || hit) begin
              delay_q[chan_q] <= edge_val + OFFSET;
              found_q[chan_q] <= 1'b1;
            end else begin
              delay_q[chan_q] <= '0;
              found_q[chan_q] <= 1'b0;
            end
            state <= APPLY;
          end else begin
            tap             <= tap + 1'b1;
            delay_q[chan_q] <= tap + 1'b1;
            state           <= LOAD;
          end
        end
        APPLY: begin
          load_q <= '0;
          state  <= SELECT;
        end
        FINISH: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign delay_o      = delay_q;
  assign load_o       = load_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign edge_found_o = found_q;
  assign scan_chan_o  = chan_q;

endmodule

// File: tb/tb_glitc_clock_phase_scan.sv
// Bench for glitc_clock_phase_scan: per-tap sample profiles drive the DUT,
// expected edges and delays come from a tap-level reference model.
module tb_glitc_clock_phase_scan;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  chan_mask_i = '0;
  logic [3:0]  sample_i = '0;
  logic [19:0] delay_o;
  logic [3:0]  load_o;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  edge_found_o;
  logic [1:0]  scan_chan_o;

  glitc_clock_phase_scan dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .chan_mask_i  (chan_mask_i),
    .sample_i     (sample_i),
    .delay_o      (delay_o),
    .load_o       (load_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .edge_found_o (edge_found_o),
    .scan_chan_o  (scan_chan_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ones [4][32];
  int k [4];
  int cur_tap [4];
  int rot [4];
  int load_cnt [4];
  int done_cnt = 0;
  int done_cyc = -1;
  int vis [$];

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int dly(input int c);
    logic [19:0] v;
    v = delay_o;
    return int'(v[c*5 +: 5]);
  endfunction

  // first tap t>0 whose majority class differs from tap t-1, else -1
  function automatic int model_edge(input int c);
    for (int t = 1; t < 32; t++)
      if ((ones[c][t] >= 32) != (ones[c][t-1] >= 32)) return t;
    return -1;
  endfunction

  function automatic int model_delay(input int c);
    int e;
    e = model_edge(c);
    return (e < 0) ? 0 : (e + 16) % 32;
  endfunction

  function automatic int lvl(input bit cl);
    return cl ? int'($urandom_range(64, 32)) : int'($urandom_range(31, 0));
  endfunction

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // monitor + sample source: 1 LOAD, 8 settle, then a 64-sample window
  initial begin
    for (int c = 0; c < 4; c++) begin
      k[c] = 1000; cur_tap[c] = 0; rot[c] = 0; load_cnt[c] = 0;
    end
    forever begin
      @(negedge clk_i);
      for (int c = 0; c < 4; c++) begin
        if (load_o[c]) begin
          k[c] = 0;
          cur_tap[c] = dly(c);
          rot[c] = int'($urandom_range(63, 0));
          load_cnt[c]++;
          if (vis.size() == 0 || vis[$] != c) begin
            vis.push_back(c);
            chk("load_chan", scan_chan_o, c);
          end
        end else if (k[c] < 1000) begin
          k[c]++;
        end
        if (k[c] >= 9 && k[c] <= 72)
          sample_i[c] = (((k[c] - 9 + rot[c]) % 64) < ones[c][cur_tap[c]]);
        else
          sample_i[c] = 1'($urandom_range(1, 0));
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic run_scan(input logic [3:0] m, input int exp_lat,
                          input int poke, input string tag);
    int s;
    int d0;
    int n;
    for (int c = 0; c < 4; c++) load_cnt[c] = 0;
    vis.delete();
    d0 = done_cnt;
    @(negedge clk_i);
    chan_mask_i = m;
    start_i = 1'b1;
    s = cyc;
    @(negedge clk_i);
    start_i = 1'b0;
    chan_mask_i = 4'($urandom);
    chk({tag, "_busy"}, busy_o, 1);
    n = 0;
    while (done_cnt == d0 && n < 6000) begin
      @(posedge clk_i);
      #1;
      start_i = (n == poke);
      if (n == poke) chan_mask_i = 4'hf;
      n++;
    end
    start_i = 1'b0;
    chk({tag, "_done_lat"}, done_cyc - s, exp_lat);
    chk({tag, "_busy_fall"}, busy_o, 0);
  endtask

  initial begin
    int e;
    int n;
    bit hitq;
    repeat (3) @(negedge clk_i);
    chk("rst_delay", delay_o, 0);
    chk("rst_load", load_o, 0);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("idle_delay", delay_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_done", done_o, 0);
    chk("idle_found", edge_found_o, 0);
    chk("idle_chan", scan_chan_o, 0);

    // single rising edge on ch0 at tap 10
    for (int t = 0; t < 32; t++) ones[0][t] = lvl(t >= 10);
    run_scan(4'b0001, 2372, -1, "single");
    chk("single_loads", load_cnt[0], 33);
    chk("single_delay", dly(0), model_delay(0));
    chk("single_found", edge_found_o[0], model_edge(0) >= 0);

    // falling edge at 20 wraps, later rise at 27 must be ignored
    for (int t = 0; t < 32; t++) ones[1][t] = lvl(t < 20 || t >= 27);
    run_scan(4'b0010, 2372, -1, "wrap");
    chk("wrap_delay", dly(1), model_delay(1));
    chk("wrap_found", edge_found_o[1], 1);
    chk("wrap_ch0_hold", dly(0), 26);

    for (int t = 0; t < 32; t++) ones[2][t] = 64;
    run_scan(4'b0100, 2372, -1, "noedge");
    chk("noedge_delay", dly(2), 0);
    chk("noedge_found", edge_found_o[2], 0);
    chk("noedge_loads", load_cnt[2], 33);

    // threshold: 31/64 is class 0, 32/64 is class 1
    for (int t = 0; t < 32; t++) ones[3][t] = (t < 5) ? lvl(0) : lvl(1'($urandom));
    ones[3][5] = 31;
    ones[3][6] = 32;
    run_scan(4'b1000, 2372, -1, "major");
    chk("major_delay", dly(3), model_delay(3));
    chk("major_edge", model_edge(3), 6);
    chk("major_found", edge_found_o[3], 1);

    // preset ch1 to delay 7 via an edge at tap 23
    for (int t = 0; t < 32; t++) ones[1][t] = lvl(t >= 23);
    run_scan(4'b0010, 2372, -1, "preset");
    chk("preset_delay", dly(1), 7);

    // random profiles on ch0/ch2, masked ch1/ch3, start while busy
    for (int t = 0; t < 32; t++) begin
      ones[0][t] = lvl(1'($urandom));
      ones[2][t] = lvl(1'($urandom));
    end
    run_scan(4'b0101, 4742, 100, "mask");
    chk("mask_visits", vis.size(), 2);
    if (vis.size() == 2) begin
      chk("mask_first", vis[0], 0);
      chk("mask_second", vis[1], 2);
    end
    chk("mask_ch0_delay", dly(0), model_delay(0));
    chk("mask_ch0_found", edge_found_o[0], model_edge(0) >= 0);
    chk("mask_ch2_delay", dly(2), model_delay(2));
    chk("mask_ch2_found", edge_found_o[2], model_edge(2) >= 0);
    chk("mask_ch1_delay", dly(1), 7);
    chk("mask_ch1_found", edge_found_o[1], 1);
    chk("mask_ch3_delay", dly(3), 22);
    chk("mask_ch3_found", edge_found_o[3], 1);
    chk("mask_ch1_loads", load_cnt[1], 0);
    chk("mask_ch3_loads", load_cnt[3], 0);

    run_scan(4'b0000, 2, -1, "empty");
    chk("empty_loads", load_cnt[0] + load_cnt[1] + load_cnt[2] + load_cnt[3], 0);

    // reset mid-scan at tap 12
    for (int t = 0; t < 32; t++) ones[0][t] = lvl(t >= 3);
    @(negedge clk_i);
    chan_mask_i = 4'b0001;
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    hitq = 1'b0;
    n = 0;
    while (!hitq && n < 2000) begin
      @(negedge clk_i);
      hitq = load_o[0] && (delay_o[4:0] == 5'd12);
      n++;
    end
    chk("rst_reach_tap12", hitq, 1);
    e = done_cnt;
    rst_n_i = 1'b0;
    #1;
    chk("abort_load", load_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_delay", delay_o, 0);
    chk("abort_found", edge_found_o, 0);
    chk("abort_done", done_o, 0);
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    repeat (3000) @(negedge clk_i);
    chk("abort_no_done", done_cnt, e);
    chk("abort_idle_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
